sram_access_arbiter: RTL and testbench

//  Shares one single-port sram instance between a burst write requester (layer loader/DMA)
//  and a wide-read requester (compute engine). It arbitrates round-robin, sequences

---
 rtl/sram_access_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one single-port sram between a burst writer and a wide reader.
// Define SRAM_ARB_BOUNDS_EN to drop out-of-range accesses and pulse err_o on them.
module sram_access_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int N_ENTRIES    = 1024,
  parameter int SRAM_WIDTH_O = 64,
  parameter int MAX_BURST    = 16,
  localparam int AW = $clog2(N_ENTRIES),
  localparam int LW = $clog2(MAX_BURST)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_cmd_valid_i,
  output logic                    wr_cmd_ready_o,
  input  logic [AW-1:0]           wr_cmd_addr_i,
  input  logic [LW-1:0]           wr_cmd_len_i,
  input  logic                    wr_data_valid_i,
  output logic                    wr_data_ready_o,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_req_valid_i,
  output logic                    rd_req_ready_o,
  input  logic [AW-1:0]           rd_req_addr_i,
  output logic                    rd_rsp_valid_o,
  input  logic                    rd_rsp_ready_i,
  output logic [SRAM_WIDTH_O-1:0] rd_rsp_data_o,
  output logic                    sram_en_o,
  output logic                    sram_we_o,
  output logic [AW-1:0]           sram_addr_o,
  output logic [DATA_WIDTH-1:0]   sram_data_o,
  input  logic [SRAM_WIDTH_O-1:0] sram_rdata_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int RD_WORDS = SRAM_WIDTH_O / DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_RSP} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] base_reg, base_next;
  logic [LW-1:0] len_reg, len_next;
  logic [LW-1:0] beat_reg, beat_next;
  logic          last_wr_reg, last_wr_next;  // 1 when the write side won the last grant
  logic          drop_reg, drop_next;
  logic          wr_oob, rd_oob;
  logic          grant_rd, grant_wr;
  logic          rsp_live;

`ifdef SRAM_ARB_BOUNDS_EN
  localparam logic [AW+1:0] DEPTH = (AW+2)'(N_ENTRIES);
  assign wr_oob = ((AW+2)'(wr_cmd_addr_i) + (AW+2)'(wr_cmd_len_i) + (AW+2)'(1)) > DEPTH;
  assign rd_oob = ((AW+2)'(rd_req_addr_i) + (AW+2)'(RD_WORDS)) > DEPTH;
`else
  assign wr_oob = 1'b0;
  assign rd_oob = 1'b0;
`endif

  // Read wins a tie unless it also won the previous grant.
  assign grant_rd = (state_reg == IDLE) && rd_req_valid_i && (!wr_cmd_valid_i || last_wr_reg);
  assign grant_wr = (state_reg == IDLE) && wr_cmd_valid_i && !grant_rd;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      len_reg     <= '0;
      beat_reg    <= '0;
      last_wr_reg <= 1'b1;
      drop_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      base_reg    <= base_next;
      len_reg     <= len_next;
      beat_reg    <= beat_next;
      last_wr_reg <= last_wr_next;
      drop_reg    <= drop_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    base_next       = base_reg;
    len_next        = len_reg;
    beat_next       = beat_reg;
    last_wr_next    = last_wr_reg;
    drop_next       = drop_reg;
    wr_cmd_ready_o  = 1'b0;
    wr_data_ready_o = 1'b0;
    rd_req_ready_o  = 1'b0;
    rd_rsp_valid_o  = 1'b0;
    rsp_live        = 1'b0;
    sram_en_o       = 1'b0;
    sram_we_o       = 1'b0;
    sram_addr_o     = '0;
    sram_data_o     = '0;
    err_o           = 1'b0;
    busy_o          = (state_reg != IDLE);

    unique case (state_reg)
      IDLE: begin
        if (grant_rd) begin
          rd_req_ready_o = 1'b1;
          sram_en_o      = !rd_oob;
          sram_addr_o    = rd_oob ? '0 : rd_req_addr_i;
          err_o          = rd_oob;
          drop_next      = rd_oob;
          last_wr_next   = 1'b0;
          state_next     = RD_RSP;
        end else if (grant_wr) begin
          wr_cmd_ready_o = 1'b1;
          base_next      = wr_cmd_addr_i;
          len_next       = wr_cmd_len_i;
          beat_next      = '0;
          err_o          = wr_oob;
          drop_next      = wr_oob;
          last_wr_next   = 1'b1;
          state_next     = WR_BURST;
        end
      end
      WR_BURST: begin
        wr_data_ready_o = 1'b1;
        if (wr_data_valid_i) begin
          // A dropped burst still consumes every beat, just without touching the sram.
          if (!drop_reg) begin
            sram_en_o   = 1'b1;
            sram_we_o   = 1'b1;
            sram_addr_o = base_reg + AW'(beat_reg);
            sram_data_o = wr_data_i;
          end
          beat_next = beat_reg + LW'(1);
          if (beat_reg == len_reg) state_next = IDLE;
        end
      end
      RD_RSP: begin
        rd_rsp_valid_o = 1'b1;
        rsp_live       = !drop_reg;
        if (rd_rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (!rst_ni) begin
      wr_cmd_ready_o  = 1'b0;
      wr_data_ready_o = 1'b0;
      rd_req_ready_o  = 1'b0;
      rd_rsp_valid_o  = 1'b0;
      rsp_live        = 1'b0;
      sram_en_o       = 1'b0;
      sram_we_o       = 1'b0;
      sram_addr_o     = '0;
      sram_data_o     = '0;
      err_o           = 1'b0;
      busy_o          = 1'b0;
    end
  end

  // The sram stays idle in RD_RSP, so its registered output is the held response.
  genvar gi;
  generate
    for (gi = 0; gi < RD_WORDS; gi++) begin : g_rsp_word
      assign rd_rsp_data_o[gi*DATA_WIDTH +: DATA_WIDTH] =
        rsp_live ? sram_rdata_i[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: sram model plus a word-level reference memory.
// Expected values follow the SRAM_ARB_BOUNDS_EN setting of the build.
module tb_sram_access_arbiter;
  localparam int DW = 32;
  localparam int NE = 1024;
  localparam int SW = 64;
  localparam int MB = 16;
  localparam int AW = 10;
  localparam int LW = 4;
`ifdef SRAM_ARB_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_cmd_valid, wr_cmd_ready;
  logic [AW-1:0] wr_cmd_addr;
  logic [LW-1:0] wr_cmd_len;
  logic          wr_data_valid, wr_data_ready;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_rsp_valid, rd_rsp_ready;
  logic [SW-1:0] rd_rsp_data;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic [SW-1:0] sram_rdata;
  logic          busy, err;
  logic [7:0]    st;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_access_arbiter #(
    .DATA_WIDTH(DW), .N_ENTRIES(NE), .SRAM_WIDTH_O(SW), .MAX_BURST(MB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_cmd_valid_i(wr_cmd_valid), .wr_cmd_ready_o(wr_cmd_ready),
    .wr_cmd_addr_i(wr_cmd_addr), .wr_cmd_len_i(wr_cmd_len),
    .wr_data_valid_i(wr_data_valid), .wr_data_ready_o(wr_data_ready), .wr_data_i(wr_data),
    .rd_req_valid_i(rd_req_valid), .rd_req_ready_o(rd_req_ready), .rd_req_addr_i(rd_req_addr),
    .rd_rsp_valid_o(rd_rsp_valid), .rd_rsp_ready_i(rd_rsp_ready), .rd_rsp_data_o(rd_rsp_data),
    .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_data_o(sram_data), .sram_rdata_i(sram_rdata),
    .busy_o(busy), .err_o(err)
  );

  assign st = {wr_cmd_ready, wr_data_ready, rd_req_ready, rd_rsp_valid, busy, err, sram_en, sram_we};

  // Pre-existing sram contents before any write.
  function automatic logic [31:0] pre_val(int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // Environment sram: one-cycle registered wide read, word at addr in the low half.
  logic [31:0] sram_mem [NE];
  bit          sram_written [NE];
  logic [31:0] ref_mem [NE];

  function automatic logic [31:0] sram_word(int a);
    return sram_written[a] ? sram_mem[a] : pre_val(a);
  endfunction

  always @(posedge clk) begin
    if (sram_en && sram_we) begin
      sram_mem[sram_addr]     <= sram_data;
      sram_written[sram_addr] <= 1'b1;
    end else if (sram_en) begin
      sram_rdata <= {sram_word((int'(sram_addr) + 1) % NE), sram_word(int'(sram_addr))};
    end
  end

  task automatic do_write(input int addr, input int len, input logic [15:0] bubbles,
                          input logic [31:0] dseed, input bit incr, input int abort_beat,
                          input bit hold_rd, input int rd_addr, input string name);
    bit drop;
    logic [7:0] es;
    logic [AW-1:0] ea;
    logic [31:0] d, ed;
    int a_exp;
    drop = BOUNDS && (addr + len + 1 > NE);
    @(negedge clk);
    wr_cmd_valid = 1'b1; wr_cmd_addr = AW'(addr); wr_cmd_len = LW'(len);
    rd_req_valid = 1'b0; wr_data_valid = 1'b0;
    #1;
    es = {1'b1, 4'b0000, drop, 2'b00};
    vectors++;
    if (st !== es) begin
      miscompares++;
      $display("FAIL %s wr_grant: got st=%b want st=%b", name, st, es);
    end
    @(posedge clk);
    for (int beat = 0; beat <= len; beat++) begin
      @(negedge clk);
      wr_cmd_valid = 1'b0; rd_req_valid = hold_rd; rd_req_addr = AW'(rd_addr);
      if (beat == abort_beat) begin
        rst_n = 1'b0; wr_data_valid = 1'b1; wr_data = $urandom;
        #1;
        vectors++;
        if ({st, sram_addr, sram_data, rd_rsp_data} !== '0) begin
          miscompares++;
          $display("FAIL %s abort_outputs: got st=%b addr=%h data=%h want all zero", name, st, sram_addr, sram_data);
        end
        @(negedge clk);
        rst_n = 1'b1; wr_data_valid = 1'b0; rd_req_valid = 1'b0;
        #1;
        vectors++;
        if ({st, sram_addr} !== '0) begin
          miscompares++;
          $display("FAIL %s abort_idle: got st=%b want 00000000", name, st);
        end
        $display("WR  %s addr=%03h len=%0d aborted at beat %0d", name, addr, len, beat);
        return;
      end
      if (bubbles[beat]) begin
        wr_data_valid = 1'b0;
        #1;
        vectors++;
        if ({st, sram_addr, sram_data} !== {8'b0100_1000, {AW{1'b0}}, 32'h0}) begin
          miscompares++;
          $display("FAIL %s wr_bubble %0d: got st=%b addr=%h want st=01001000 addr=0", name, beat, st, sram_addr);
        end
        @(negedge clk);
      end
      d = incr ? dseed + 32'(beat) : $urandom;
      wr_data_valid = 1'b1; wr_data = d;
      a_exp = (addr + beat) % NE;
      es = {6'b010010, !drop, !drop};
      ea = drop ? '0 : AW'(a_exp);
      ed = drop ? 32'h0 : d;
      #1;
      vectors++;
      if ({st, sram_addr, sram_data} !== {es, ea, ed}) begin
        miscompares++;
        $display("FAIL %s wr_beat %0d: got st=%b addr=%h data=%h want st=%b addr=%h data=%h",
                 name, beat, st, sram_addr, sram_data, es, ea, ed);
      end
      if (!drop) ref_mem[a_exp] = d;
      @(posedge clk);
    end
    #1;
    wr_data_valid = 1'b0; rd_req_valid = 1'b0;
    $display("WR  %s addr=%03h len=%0d drop=%0d", name, addr, len, drop);
  endtask

  task automatic do_read(input int addr, input int hold, input string name);
    bit oob;
    logic [63:0] exp_d;
    logic [7:0] es;
    logic [AW-1:0] ea;
    oob = BOUNDS && (addr + 2 > NE);
    exp_d = oob ? 64'h0 : {ref_mem[(addr + 1) % NE], ref_mem[addr]};
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_addr = AW'(addr); rd_rsp_ready = 1'b0; wr_cmd_valid = 1'b0;
    #1;
    es = {2'b00, 1'b1, 2'b00, oob, !oob, 1'b0};
    ea = oob ? '0 : AW'(addr);
    vectors++;
    if ({st, sram_addr, sram_data} !== {es, ea, 32'h0}) begin
      miscompares++;
      $display("FAIL %s rd_grant: got st=%b addr=%h data=%h want st=%b addr=%h data=0", name, st, sram_addr, sram_data, es, ea);
    end
    @(negedge clk);
    rd_req_valid = 1'b0;
    for (int c = 0; c <= hold; c++) begin
      if (c == hold) rd_rsp_ready = 1'b1;
      #1;
      vectors++;
      if ({st, rd_rsp_data} !== {8'b0001_1000, exp_d}) begin
        miscompares++;
        $display("FAIL %s rd_rsp cycle %0d: got st=%b data=%h want st=00011000 data=%h", name, c, st, rd_rsp_data, exp_d);
      end
      @(negedge clk);
    end
    rd_rsp_ready = 1'b0;
    #1;
    vectors++;
    if (st !== 8'b0) begin
      miscompares++;
      $display("FAIL %s rd_done: got st=%b want 00000000", name, st);
    end
    $display("RD  %s addr=%03h hold=%0d data=%h oob=%0d", name, addr, hold, exp_d, oob);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_cmd_valid = 1'b1; rd_req_valid = 1'b1; wr_data_valid = 1'b1; rd_rsp_ready = 1'b1;
    wr_cmd_addr = AW'($urandom); rd_req_addr = AW'($urandom); wr_cmd_len = LW'($urandom);
    wr_data = $urandom;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({st, sram_addr, sram_data, rd_rsp_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got st=%b addr=%h data=%h want all zero", st, sram_addr, sram_data);
    end
    @(negedge clk);
    rst_n = 1'b1; wr_cmd_valid = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b0;
    #1;
    vectors++;
    if ({st, sram_addr, sram_data} !== '0) begin
      miscompares++;
      $display("FAIL idle_ignores_data: got st=%b addr=%h want all zero", st, sram_addr);
    end
    @(negedge clk);
    wr_data_valid = 1'b0;
    $display("RST released, idle with stray write data ignored");
  endtask

  task automatic test_arbitration();
    int wa, ra;
    bit exp_rd;
    logic [31:0] d;
    logic [63:0] exp_d;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_rd = (k % 2 == 0);
      wa = $urandom_range(0, NE - 2);
      ra = $urandom_range(0, NE - 2);
      exp_d = {ref_mem[ra + 1], ref_mem[ra]};
      @(negedge clk);
      wr_cmd_valid = 1'b1; rd_req_valid = 1'b1; rd_rsp_ready = 1'b1;
      wr_cmd_addr = AW'(wa); wr_cmd_len = '0; rd_req_addr = AW'(ra);
      #1;
      vectors++;
      if ({wr_cmd_ready, rd_req_ready} !== {!exp_rd, exp_rd}) begin
        miscompares++;
        $display("FAIL arb_grant %0d: got wr=%b rd=%b want wr=%b rd=%b", k, wr_cmd_ready, rd_req_ready, !exp_rd, exp_rd);
      end
      @(negedge clk);
      d = $urandom;
      wr_data_valid = !exp_rd; wr_data = d;
      #1;
      vectors++;
      if (exp_rd) begin
        if ({st, rd_rsp_data} !== {8'b0001_1000, exp_d}) begin
          miscompares++;
          $display("FAIL arb_rd_rsp %0d: got st=%b data=%h want st=00011000 data=%h", k, st, rd_rsp_data, exp_d);
        end
      end else begin
        if ({st, sram_addr, sram_data} !== {8'b0100_1011, AW'(wa), d}) begin
          miscompares++;
          $display("FAIL arb_wr_beat %0d: got st=%b addr=%h data=%h want st=01001011 addr=%h data=%h",
                   k, st, sram_addr, sram_data, AW'(wa), d);
        end
        ref_mem[wa] = d;
      end
      @(posedge clk);
      #1 wr_data_valid = 1'b0;
      $display("ARB grant %0d to %s", k, exp_rd ? "read" : "write");
    end
    @(negedge clk);
    wr_cmd_valid = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(0, NE - 1), $urandom_range(0, MB - 1), 16'($urandom),
                 $urandom, 1'b0, -1, 1'b0, 0, "rand");
      else
        do_read($urandom_range(0, NE - 1), $urandom_range(0, 2), "rand");
    end
  endtask

  initial begin
    for (int i = 0; i < NE; i++) ref_mem[i] = pre_val(i);
    wr_cmd_valid = 1'b0; wr_cmd_addr = '0; wr_cmd_len = '0;
    wr_data_valid = 1'b0; wr_data = '0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_rsp_ready = 1'b0;

    test_reset();
    // burst with a bubble after beat 1, then read it back with a held response
    do_write(16, 3, 16'b0100, 32'hA0, 1'b1, -1, 1'b0, 0, "burst");
    do_read(16, 3, "hold");
    test_arbitration();
    // read pending throughout a len=7 burst, granted in the first idle cycle
    do_write(100, 7, 16'h0000, 32'h0, 1'b0, -1, 1'b1, 200, "rd_wait");
    do_read(200, 0, "rd_wait");
    // reset at beat 2, then a fresh burst at its own base
    do_write(300, 5, 16'h0000, 32'h0, 1'b0, 2, 1'b0, 0, "abort");
    do_write(400, 2, 16'h0002, 32'h0, 1'b0, -1, 1'b0, 0, "fresh");
    do_read(300, 0, "partial");
    // near the top of the array: dropped with the bounds option, wrapped without
    do_write(1020, 7, 16'h0000, 32'h0, 1'b0, -1, 1'b0, 0, "edge");
    do_read(1023, 1, "edge");
    do_read(0, 0, "wrapped");
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
